div_ctrl: RTL
=============

DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: div_valid  in  1  request present from EX stage.
REQ-004 SHALL have ports: div_ready  out  1  block can accept a request (high only in IDLE).
REQ-005 SHALL have ports: div_op  in  2  00 div.w, 01 mod.w, 10 div.wu, 11 mod.wu.
REQ-006 SHALL have ports: div_src1  in  32  dividend (rj).
REQ-007 SHALL have ports: div_src2  in  32  divisor (rk).
REQ-008 SHALL have ports: div_flush  in  1  cancel in-flight operation (exception/ertn).
REQ-009 SHALL have ports: div_res_valid  out  1  result available.
REQ-010 SHALL have ports: div_res_ready  in  1  consumer takes result.
REQ-011 SHALL have ports: div_result  out  32  quotient or remainder per latched div_op.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, FIX, DONE.
REQ-013 SHALL accept a request on a rising edge where div_valid & div_ready & ~div_flush; div_op, |src1|, |src2| and both source signs latched on that edge; signs forced to 0 for div.wu/mod.wu.
REQ-014 SHALL transition IDLE->CALC on acceptance; inputs are ignored outside acceptance edges.
REQ-015 SHALL perform one restoring shift-subtract iteration per cycle in CALC, using a 33-bit subtract (remainder minus divisor); borrow selects quotient bit 0/1; a 6-bit counter selects CALC->FIX after exactly 32 iterations.
REQ-016 SHALL in FIX: negate quotient when sign1^sign2, negate remainder when sign1, select quotient (div_op[0]=0) or remainder (div_op[0]=1) into the div_result register; FIX->DONE unconditionally.
REQ-017 SHALL assert div_res_valid only in DONE, first visible 34 cycles after the accepting edge (32 CALC + 1 FIX + 1).
REQ-018 SHALL hold div_result and div_res_valid stable in DONE until an edge with div_res_ready=1, then go DONE->IDLE; div_ready returns high the following cycle (no same-cycle re-accept).
REQ-019 SHALL give, for signed 0x80000000 / 0xFFFFFFFF, quotient 0x80000000 and remainder 0x00000000 with no exception.
REQ-020 SHALL give, for divisor zero in any mode, quotient 0xFFFFFFFF and remainder equal to div_src1 as supplied, overriding the FIX sign correction.
REQ-021 SHALL, on div_flush=1 at any edge in any state, go to IDLE with div_res_valid=0 on the next cycle, discarding the result; flush wins over simultaneous div_valid or div_res_ready.
REQ-022 SHALL keep div_result unchanged outside FIX (and the REQ-025 fast path).

Reset
REQ-023 SHALL on reset=1 at an edge enter IDLE; div_res_valid=0, div_ready=1 the next cycle; div_result=0x00000000; iteration counter=0; reset dominates flush and valid.
REQ-024 SHALL abort any operation in progress when reset is asserted mid-operation, with no result produced.

Configuration
REQ-025 SHALL, with macro DIV_ZERO_FAST_EN defined, route an accepted request with div_src2==0 directly IDLE->DONE with the REQ-020 result, so div_res_valid is visible 1 cycle after acceptance.
REQ-026 SHALL, without DIV_ZERO_FAST_EN, run divide-by-zero through full CALC/FIX (34-cycle latency) with the identical REQ-020 result.

Verification
REQ-027 SHALL cover: div.w 100/7 -> 0x0000000E; mod.w 100/7 -> 0x00000002; res_valid exactly 34 cycles after accept.
REQ-028 SHALL cover: div.w 0xFFFFFFF9/2 -> 0xFFFFFFFD; mod.w -> 0xFFFFFFFF; div.wu 0xFFFFFFFF/2 -> 0x7FFFFFFF; mod.wu -> 0x00000001.
REQ-029 SHALL cover: div.w 0x80000000/0xFFFFFFFF -> 0x80000000; mod.w -> 0x00000000.
REQ-030 SHALL cover: div.w 0x12345678/0 -> 0xFFFFFFFF, mod.w -> 0x12345678; latency 1 cycle with DIV_ZERO_FAST_EN, 34 cycles without.
REQ-031 SHALL cover: div_flush at iteration 10 -> res_valid never rises, div_ready high next cycle; new request 9/3 then -> 0x00000003.
REQ-032 SHALL cover: div_res_ready held low 5 cycles in DONE -> div_result stable for all 5; reset asserted mid-CALC -> IDLE, div_result=0.

Source files
------------

// File: rtl/div_ctrl.sv
// div_ctrl: 32-bit iterative divider for the EX stage (div.w, mod.w, div.wu, mod.wu).
// Restoring shift-subtract, one quotient bit per cycle, 32 iterations,
// followed by a sign-fix cycle and a result-hold state with valid/ready handshake.
// Optional build macro DIV_ZERO_FAST_EN: a zero divisor skips the iteration
// and jumps straight to DONE with the divide-by-zero result.
module div_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        div_valid,
  output logic        div_ready,
  input  logic [1:0]  div_op,
  input  logic [31:0] div_src1,
  input  logic [31:0] div_src2,
  input  logic        div_flush,
  output logic        div_res_valid,
  input  logic        div_res_ready,
  output logic [31:0] div_result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state;
  state_t next_state;

  logic        accept;
  logic        in_sign1;
  logic        in_sign2;
  logic [31:0] abs1;
  logic [31:0] abs2;
  logic        src2_zero;

  logic        rem_sel_q;
  logic        sign1_q;
  logic        sign2_q;
  logic        zero_q;
  logic [31:0] divisor_q;
  logic [31:0] rem_q;
  logic [31:0] quo_q;
  logic [5:0]  iter_cnt;

  logic [32:0] partial;
  logic [32:0] diff;
  logic        borrow;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
  logic [31:0] fix_value;

  // Unsigned ops treat both operands as non-negative, so their signs are forced to 0
  assign in_sign1  = ~div_op[1] & div_src1[31];
  assign in_sign2  = ~div_op[1] & div_src2[31];
  assign abs1      = in_sign1 ? (32'd0 - div_src1) : div_src1;
  assign abs2      = in_sign2 ? (32'd0 - div_src2) : div_src2;
  assign src2_zero = (div_src2 == 32'd0);
  assign accept    = div_valid & (state == IDLE) & ~div_flush;

  // The partial remainder is always below the divisor, so the shifted value fits in
  // 33 bits and bit 32 of the 33-bit difference is the borrow.
  assign partial = {rem_q, quo_q[31]};
  assign diff    = partial - {1'b0, divisor_q};
  assign borrow  = diff[32];

  // Sign correction; a zero divisor forces an all-ones quotient, and the remainder
  // path already reproduces the original dividend after its sign correction.
  assign quo_fix   = zero_q ? 32'hFFFF_FFFF
                            : ((sign1_q ^ sign2_q) ? (32'd0 - quo_q) : quo_q);
  assign rem_fix   = sign1_q ? (32'd0 - rem_q) : rem_q;
  assign fix_value = rem_sel_q ? rem_fix : quo_fix;

  // State register; reset and flush both return to IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and handshake outputs; flush overrides every transition
  always_comb begin
    next_state    = state;
    div_ready     = 1'b0;
    div_res_valid = 1'b0;
    case (state)
      IDLE: begin
        div_ready = 1'b1;
        if (accept) begin
`ifdef DIV_ZERO_FAST_EN
          next_state = src2_zero ? DONE : CALC;
`else
          next_state = CALC;
`endif
        end
      end
      CALC: begin
        if (iter_cnt == 6'd31) begin
          next_state = FIX;
        end
      end
      FIX: begin
        next_state = DONE;
      end
      DONE: begin
        div_res_valid = 1'b1;
        if (div_res_ready) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
    if (div_flush) begin
      next_state = IDLE;
    end
  end

  // Datapath: latch operands on accept, iterate in CALC, write the result in FIX
  always_ff @(posedge clk) begin
    if (reset) begin
      rem_sel_q  <= 1'b0;
      sign1_q    <= 1'b0;
      sign2_q    <= 1'b0;
      zero_q     <= 1'b0;
      divisor_q  <= 32'd0;
      rem_q      <= 32'd0;
      quo_q      <= 32'd0;
      iter_cnt   <= 6'd0;
      div_result <= 32'd0;
    end else if (accept) begin
      rem_sel_q <= div_op[0];
      sign1_q   <= in_sign1;
      sign2_q   <= in_sign2;
      zero_q    <= src2_zero;
      divisor_q <= abs2;
      rem_q     <= 32'd0;
      quo_q     <= abs1;
      iter_cnt  <= 6'd0;
`ifdef DIV_ZERO_FAST_EN
      if (src2_zero) begin
        div_result <= div_op[0] ? div_src1 : 32'hFFFF_FFFF;
      end
`endif
    end else if (!div_flush) begin
      if (state == CALC) begin
        rem_q    <= borrow ? partial[31:0] : diff[31:0];
        quo_q    <= {quo_q[30:0], ~borrow};
        iter_cnt <= iter_cnt + 6'd1;
      end else if (state == FIX) begin
        div_result <= fix_value;
      end
    end
  end

endmodule
